// File: rtl/messbauer_defs.sv
// rtl/messbauer_defs.sv - shared FSM encoding, default sizes and clog2 helper
package messbauer_defs;

  localparam int DEF_CHANNEL_NUMBER     = 512;
  localparam int DEF_COUNTER_WIDTH      = 32;
  localparam int DEF_COINCIDENCE_WINDOW = 4;

  localparam logic [2:0] ST_IDLE      = 3'd0;
  localparam logic [2:0] ST_ACQUIRE   = 3'd1;
  localparam logic [2:0] ST_COMMIT_RD = 3'd2;
  localparam logic [2:0] ST_COMMIT_WR = 3'd3;
  localparam logic [2:0] ST_CLEAR     = 3'd4;

  function automatic int clog2(input int value);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < value) r = i + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/messbauer_input_conditioner.sv
// rtl/messbauer_input_conditioner.sv - pin synchronizers, edge detectors and coincidence-window discriminator
module messbauer_input_conditioner
  import messbauer_defs::*;
#(
  parameter int COINCIDENCE_WINDOW = DEF_COINCIDENCE_WINDOW
) (
  input  logic aclk,
  input  logic areset,
  input  logic start,
  input  logic channel,
  input  logic lower_threshold,
  input  logic upper_threshold,
  output logic start_edge,
  output logic channel_edge,
  output logic event_accept
);

  localparam int WW = clog2(COINCIDENCE_WINDOW + 1);

  logic [3:0]    pins;
  logic [3:0]    sync1_q, sync2_q, prev_q, edge_q;
  logic [WW-1:0] win_q;
  logic          veto_q;
  logic          accept_q;
  logic          lower_e, upper_e;

  assign pins = {upper_threshold, lower_threshold, channel, start};

  // Two-flop synchronizer plus a registered rising-edge pulse (3 cycles pin-to-pulse)
  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      sync1_q <= '0;
      sync2_q <= '0;
      prev_q  <= '0;
      edge_q  <= '0;
    end else begin
      sync1_q <= pins;
      sync2_q <= sync1_q;
      prev_q  <= sync2_q;
      edge_q  <= sync2_q & ~prev_q;
    end
  end

  assign start_edge   = edge_q[0];
  assign channel_edge = edge_q[1];
  assign lower_e      = edge_q[2];
  assign upper_e      = edge_q[3];

  // Window opens on a lower edge; any upper edge up to its last cycle vetoes, no retrigger
  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      win_q    <= '0;
      veto_q   <= 1'b0;
      accept_q <= 1'b0;
    end else begin
      accept_q <= 1'b0;
      if (win_q == '0) begin
        if (lower_e) begin
          win_q  <= WW'(COINCIDENCE_WINDOW);
          veto_q <= upper_e;
        end
      end else begin
        win_q <= win_q - 1'b1;
        if (upper_e) veto_q <= 1'b1;
        if (win_q == WW'(1) && !veto_q && !upper_e) accept_q <= 1'b1;
      end
    end
  end

  assign event_accept = accept_q;

endmodule

// File: rtl/messbauer_spectrum_accumulator.sv
// rtl/messbauer_spectrum_accumulator.sv - per-channel spectrum accumulator; MESSBAUER_SWEEP_COUNTER_EN adds sweep_count
module messbauer_spectrum_accumulator
  import messbauer_defs::*;
#(
  parameter int  CHANNEL_NUMBER     = DEF_CHANNEL_NUMBER,
  parameter int  COUNTER_WIDTH      = DEF_COUNTER_WIDTH,
  parameter int  COINCIDENCE_WINDOW = DEF_COINCIDENCE_WINDOW,
  localparam int AW                 = clog2(CHANNEL_NUMBER)
) (
  input  logic                     aclk,
  input  logic                     areset,
  input  logic                     start,
  input  logic                     channel,
  input  logic                     lower_threshold,
  input  logic                     upper_threshold,
  input  logic                     clear,
  output logic                     busy,
  input  logic                     rd_en,
  input  logic [AW-1:0]            rd_addr,
  output logic [COUNTER_WIDTH-1:0] rd_data,
  output logic                     rd_valid
`ifdef MESSBAUER_SWEEP_COUNTER_EN
  ,
  output logic [31:0]              sweep_count
`endif
);

  localparam int CW = COUNTER_WIDTH;

  logic          start_edge, channel_edge, event_accept;
  logic [2:0]    state_q, state_d;
  logic [AW-1:0] idx_q, idx_d, cidx_q, cidx_d, clr_addr_q, clr_addr_d;
  logic [CW-1:0] cnt_q, cnt_d, ccnt_q, ccnt_d;
  logic          last_q, last_d, pend_chan_q, pend_chan_d, pend_clr_q, pend_clr_d;
  logic [CW-1:0] cnt_ev, rdata_a_q, sum_sat, mem_wdata;
  logic [CW:0]   sum_w;
  logic          mem_we;
  logic [AW-1:0] mem_waddr;
  logic [CW-1:0] mem_q [CHANNEL_NUMBER];

  messbauer_input_conditioner #(.COINCIDENCE_WINDOW(COINCIDENCE_WINDOW)) u_cond (
    .aclk            (aclk),
    .areset          (areset),
    .start           (start),
    .channel         (channel),
    .lower_threshold (lower_threshold),
    .upper_threshold (upper_threshold),
    .start_edge      (start_edge),
    .channel_edge    (channel_edge),
    .event_accept    (event_accept)
  );

  assign cnt_ev  = (event_accept && !(&cnt_q)) ? cnt_q + 1'b1 : cnt_q;
  assign sum_w   = {1'b0, rdata_a_q} + {1'b0, ccnt_q};
  assign sum_sat = sum_w[CW] ? '1 : sum_w[CW-1:0];
  assign busy    = (state_q == ST_COMMIT_RD) || (state_q == ST_COMMIT_WR) || (state_q == ST_CLEAR);

  // Sweep sequencing: channel closes, commit read-modify-write, wipe
  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    cnt_d       = cnt_q;
    cidx_d      = cidx_q;
    ccnt_d      = ccnt_q;
    last_d      = last_q;
    pend_chan_d = pend_chan_q;
    pend_clr_d  = pend_clr_q;
    clr_addr_d  = clr_addr_q;
    case (state_q)
      ST_IDLE: begin
        pend_chan_d = 1'b0;
        if (clear || pend_clr_q) begin
          state_d    = ST_CLEAR;
          pend_clr_d = 1'b0;
          clr_addr_d = '0;
        end else if (start_edge) begin
          state_d = ST_ACQUIRE;
          idx_d   = '0;
          cnt_d   = '0;
        end
      end
      ST_ACQUIRE: begin
        cnt_d = cnt_ev;
        if (clear) pend_clr_d = 1'b1;
        if (start_edge || channel_edge || pend_chan_q) begin
          // A same-cycle accepted event belongs to the channel being closed
          cidx_d      = idx_q;
          ccnt_d      = cnt_ev;
          cnt_d       = '0;
          pend_chan_d = 1'b0;
          state_d     = ST_COMMIT_RD;
          if (start_edge) begin
            idx_d  = '0;
            last_d = 1'b0;
          end else begin
            last_d = (idx_q == AW'(CHANNEL_NUMBER - 1));
            idx_d  = (idx_q == AW'(CHANNEL_NUMBER - 1)) ? '0 : idx_q + 1'b1;
          end
        end
      end
      ST_COMMIT_RD, ST_COMMIT_WR: begin
        cnt_d = cnt_ev;
        if (clear) pend_clr_d = 1'b1;
        if (channel_edge) pend_chan_d = 1'b1;
        if (state_q == ST_COMMIT_RD) state_d = ST_COMMIT_WR;
        else                         state_d = last_q ? ST_IDLE : ST_ACQUIRE;
      end
      ST_CLEAR: begin
        clr_addr_d = clr_addr_q + 1'b1;
        if (clr_addr_q == AW'(CHANNEL_NUMBER - 1)) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Control state registers
  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      state_q     <= ST_IDLE;
      idx_q       <= '0;
      cnt_q       <= '0;
      cidx_q      <= '0;
      ccnt_q      <= '0;
      last_q      <= 1'b0;
      pend_chan_q <= 1'b0;
      pend_clr_q  <= 1'b0;
      clr_addr_q  <= '0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      cnt_q       <= cnt_d;
      cidx_q      <= cidx_d;
      ccnt_q      <= ccnt_d;
      last_q      <= last_d;
      pend_chan_q <= pend_chan_d;
      pend_clr_q  <= pend_clr_d;
      clr_addr_q  <= clr_addr_d;
    end
  end

  assign mem_we    = (state_q == ST_COMMIT_WR) || (state_q == ST_CLEAR);
  assign mem_waddr = (state_q == ST_CLEAR) ? clr_addr_q : cidx_q;
  assign mem_wdata = (state_q == ST_CLEAR) ? '0 : sum_sat;

  // Spectrum RAM port A: commit read-modify-write and wipe writes
  always_ff @(posedge aclk) begin
    if (mem_we) mem_q[mem_waddr] <= mem_wdata;
    if (state_q == ST_COMMIT_RD) rdata_a_q <= mem_q[cidx_q];
  end

  // Spectrum RAM port B: host readout, read-before-write on address collision
  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      rd_valid <= 1'b0;
      rd_data  <= '0;
    end else begin
      rd_valid <= rd_en;
      if (rd_en) rd_data <= mem_q[rd_addr];
    end
  end

`ifdef MESSBAUER_SWEEP_COUNTER_EN
  logic [31:0] sweep_q;

  // Completed-sweep counter; restarts do not count, a finished wipe zeroes it
  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      sweep_q <= '0;
    end else if (state_q == ST_CLEAR && clr_addr_q == AW'(CHANNEL_NUMBER - 1)) begin
      sweep_q <= '0;
    end else if (state_q == ST_COMMIT_WR && last_q && !(&sweep_q)) begin
      sweep_q <= sweep_q + 1'b1;
    end
  end

  assign sweep_count = sweep_q;
`endif

endmodule

// File: tb/tb_messbauer_spectrum_accumulator.sv
// tb/tb_messbauer_spectrum_accumulator.sv - randomized self-checking bench against a spectrum model
module tb_messbauer_spectrum_accumulator;

  localparam int N = 512;

  logic        aclk = 1'b0;
  logic        areset, start, channel, lower_threshold, upper_threshold, clear, rd_en;
  logic [8:0]  rd_addr;
  logic        busy, rd_valid;
  logic [31:0] rd_data;
`ifdef MESSBAUER_SWEEP_COUNTER_EN
  logic [31:0] sweep_count;
`endif

  int          n_checks = 0;
  int          n_fail   = 0;
  logic [31:0] model [N];
  int          lone_n [N];
  int          veto_n [N];
  int          late_n [N];

  always #5 aclk = ~aclk;

  messbauer_spectrum_accumulator dut (
    .aclk            (aclk),
    .areset          (areset),
    .start           (start),
    .channel         (channel),
    .lower_threshold (lower_threshold),
    .upper_threshold (upper_threshold),
    .clear           (clear),
    .busy            (busy),
    .rd_en           (rd_en),
    .rd_addr         (rd_addr),
    .rd_data         (rd_data),
    .rd_valid        (rd_valid)
`ifdef MESSBAUER_SWEEP_COUNTER_EN
    ,
    .sweep_count     (sweep_count)
`endif
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] sat_add(input logic [31:0] a, input int n);
    longint s;
    s = longint'(a) + longint'(n);
    return (s > 64'h0000_0000_FFFF_FFFF) ? 32'hFFFF_FFFF : s[31:0];
  endfunction

  task automatic cyc(input int n);
    repeat (n) @(negedge aclk);
  endtask

  task automatic pulse_start();
    start = 1'b1; cyc(2); start = 1'b0; cyc(18);
  endtask

  task automatic pulse_channel();
    channel = 1'b1; cyc(2); channel = 1'b0; cyc(18);
  endtask

  task automatic ev_lone();
    lower_threshold = 1'b1; cyc(2); lower_threshold = 1'b0; cyc(10);
  endtask

  task automatic ev_veto();
    lower_threshold = 1'b1; cyc(2); lower_threshold = 1'b0;
    upper_threshold = 1'b1; cyc(2); upper_threshold = 1'b0; cyc(10);
  endtask

  task automatic ev_late();
    lower_threshold = 1'b1; cyc(2); lower_threshold = 1'b0; cyc(4);
    upper_threshold = 1'b1; cyc(2); upper_threshold = 1'b0; cyc(10);
  endtask

  task automatic zero_plan();
    for (int c = 0; c < N; c++) begin
      lone_n[c] = 0; veto_n[c] = 0; late_n[c] = 0;
    end
  endtask

  task automatic run_sweep();
    pulse_start();
    for (int c = 0; c < N; c++) begin
      repeat (lone_n[c]) ev_lone();
      repeat (veto_n[c]) ev_veto();
      repeat (late_n[c]) ev_late();
      pulse_channel();
      model[c] = sat_add(model[c], lone_n[c] + late_n[c]);
    end
    cyc(5);
  endtask

  task automatic do_read(input int a, output logic [31:0] d, output logic v);
    rd_en = 1'b1; rd_addr = 9'(a); cyc(1); rd_en = 1'b0;
    d = rd_data; v = rd_valid;
  endtask

  task automatic readout_all(input string tag);
    logic [31:0] d;
    logic        v;
    for (int a = 0; a < N; a++) begin
      do_read(a, d, v);
      check($sformatf("%s_valid[%0d]", tag, a), 32'(v), 32'd1);
      check($sformatf("%s[%0d]", tag, a), d, model[a]);
    end
    cyc(1);
    check({tag, "_valid_idle"}, 32'(rd_valid), 32'd0);
  endtask

  task automatic do_clear();
    int k;
    k = 0;
    clear = 1'b1; cyc(1); clear = 1'b0;
    check("clear_busy", 32'(busy), 32'd1);
    while (busy && k < 700) begin cyc(1); k++; end
    check("clear_len", 32'(k), 32'd512);
    check("clear_busy_drop", 32'(busy), 32'd0);
    for (int c = 0; c < N; c++) model[c] = '0;
  endtask

  task automatic pulse_channel_catch(input string tag);
    int k;
    k = 0;
    channel = 1'b1; cyc(2); channel = 1'b0;
    while (!busy && k < 10) begin cyc(1); k++; end
    check({tag, "_busy"}, 32'(busy), 32'd1);
    check({tag, "_lag"}, 32'(k), 32'd2);
  endtask

  initial begin
    logic [31:0] d;
    logic        v;
    int          k;
    int          seen;
    areset = 1'b1; start = 1'b0; channel = 1'b0; lower_threshold = 1'b0;
    upper_threshold = 1'b0; clear = 1'b0; rd_en = 1'b0; rd_addr = '0;
    cyc(3);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_rd_valid", 32'(rd_valid), 32'd0);
    check("rst_rd_data", rd_data, 32'd0);
    areset = 1'b0;
    cyc(2);
    check("post_rst_busy", 32'(busy), 32'd0);

    do_clear();

    // Deterministic sweep: lone events, a vetoed pair, a late upper, channel 10 marker
    zero_plan();
    lone_n[5] = 3; veto_n[6] = 1; late_n[7] = 1; lone_n[10] = 1;
    run_sweep();
    check("sweepA_busy_end", 32'(busy), 32'd0);
    readout_all("sweepA");

    // Randomized sweep accumulating on top of the first one
    zero_plan();
    for (int c = 0; c < N; c++) begin
      if ($urandom_range(0, 15) == 0) lone_n[c] = int'($urandom_range(1, 2));
      if ($urandom_range(0, 31) == 0) veto_n[c] = 1;
      if ($urandom_range(0, 31) == 0) late_n[c] = 1;
    end
    lone_n[10] = 1; late_n[10] = 0;
    run_sweep();
    readout_all("sweepB");
    do_read(10, d, v);
    check("ch10_two_sweeps", d, 32'd2);
`ifdef MESSBAUER_SWEEP_COUNTER_EN
    check("sweep_count", sweep_count, 32'd2);
`endif

    // Read/write collision on address 7: old 4, new 6
    do_clear();
    pulse_start();
    repeat (7) pulse_channel();
    repeat (4) ev_lone();
    pulse_start();
    repeat (7) pulse_channel();
    repeat (2) ev_lone();
    pulse_channel_catch("commit7");
    cyc(1);
    do_read(7, d, v);
    check("collide_valid", 32'(v), 32'd1);
    check("collide_old", d, 32'd4);
    do_read(7, d, v);
    check("collide_new", d, 32'd6);
    cyc(15);

    // Reset while the commit write is in flight
    pulse_channel_catch("commit8");
    cyc(1);
    areset = 1'b1;
    cyc(2);
    check("midrst_busy", 32'(busy), 32'd0);
    check("midrst_rd_valid", 32'(rd_valid), 32'd0);
    check("midrst_rd_data", rd_data, 32'd0);
    areset = 1'b0;
    cyc(1);
    check("after_rst_busy", 32'(busy), 32'd0);
    channel = 1'b1; cyc(2); channel = 1'b0;
    seen = 0;
    for (k = 0; k < 8; k++) begin cyc(1); if (busy) seen = 1; end
    check("idle_ignores_channel", 32'(seen), 32'd0);
    do_clear();
    readout_all("after_clear");

    // Saturation of the committed sum
    dut.mem_q[0] = 32'hFFFF_FFFE;
    model[0] = 32'hFFFF_FFFE;
    pulse_start();
    repeat (5) ev_lone();
    pulse_channel();
    model[0] = sat_add(model[0], 5);
    do_read(0, d, v);
    check("sat_ch0", d, model[0]);
    check("sat_ch0_const", d, 32'hFFFF_FFFF);
    do_read(1, d, v);
    check("sat_ch1", d, 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached, got timeout expected completion");
    $fatal(1);
  end

endmodule

// File: doc/messbauer_spectrum_accumulator.md
Name: messbauer_spectrum_accumulator

Overview:
- Receiving end of the Mössbauer generator/discriminator signal set: consumes start, channel, lower_threshold and upper_threshold.
- Qualifies differential-discriminator events and bins them per velocity channel.
- Accumulates counts into an on-chip spectrum RAM across sweeps.
- Sits on the capture board opposite the test environment; exposes a synchronous readout port for host transfer.

Parameters:
- CHANNEL_NUMBER, 512, spectrum channels per sweep; address width = clog2(CHANNEL_NUMBER).
- COUNTER_WIDTH, 32, spectrum word width.
- COINCIDENCE_WINDOW, 4, cycles after a lower edge during which an upper edge vetoes the event.

Ports:
- aclk  in  1  system clock
- areset  in  1  asynchronous active-high reset
- start  in  1  async sweep start pulse
- channel  in  1  async channel-advance pulse
- lower_threshold  in  1  async lower discriminator pulse
- upper_threshold  in  1  async upper discriminator pulse
- clear  in  1  request RAM wipe (single-cycle pulse)
- busy  out  1  high while a wipe or commit is in progress
- rd_en  in  1  readout strobe
- rd_addr  in  clog2(CHANNEL_NUMBER)  readout address
- rd_data  out  COUNTER_WIDTH  readout word
- rd_valid  out  1  rd_data valid

Behaviour:
- Reset (areset high, any time, including mid-commit or mid-wipe):
  - FSM to IDLE; busy=0, rd_valid=0, rd_data=0.
  - Channel index and event counter = 0.
  - RAM contents not guaranteed; host must issue clear after power-up.
- Input conditioning: all four inputs pass through 2-FF synchronizers and a rising-edge detector. Edge pulses lag pin edges by 3 cycles.
- Discriminator:
  - A lower edge opens a window of COINCIDENCE_WINDOW cycles.
  - An upper edge in the same cycle or inside the window vetoes the event.
  - If the window expires with no veto, one accepted-event pulse is produced.
  - A lower edge while a window is open is ignored (no retrigger).
- Event counter: increments on an accepted event and saturates at all-ones.
- FSM states: IDLE, ACQUIRE, COMMIT_RD, COMMIT_WR, CLEAR.
  - IDLE: start edge -> ACQUIRE, index=0, counter=0. clear -> CLEAR.
  - ACQUIRE, channel edge: latch counter and index into commit registers, counter=0, index+1, go COMMIT_RD.
    - An event accepted in the same cycle goes to the closing channel.
    - If index==CHANNEL_NUMBER-1, commit then -> IDLE (sweep complete).
  - ACQUIRE, start edge: restart the sweep. The partial channel is committed first, then index=0.
  - COMMIT_RD: read RAM[commit index] (1-cycle RAM latency) -> COMMIT_WR.
  - COMMIT_WR: write saturating sum RAM + commit count -> back to ACQUIRE or IDLE.
  - Events accepted during COMMIT_* are counted into the new channel.
  - Channel edges are guaranteed ≥4 cycles apart. An edge arriving during COMMIT_* is held in a 1-deep pending flag and handled on return to ACQUIRE.
  - clear in ACQUIRE is latched and serviced on the next entry to IDLE.
  - CLEAR: writes 0 to address 0..CHANNEL_NUMBER-1, one per cycle, busy=1, then -> IDLE. start and channel edges are ignored in CLEAR.
- busy is high in COMMIT_RD, COMMIT_WR and CLEAR.
- Readout uses the second RAM port and is independent of the FSM.
  - rd_en sampled at cycle N -> rd_data and rd_valid=1 at N+1. rd_valid=0 otherwise.
  - rd_data holds its last value.
  - Same-cycle read/write to one address returns the old value.

Optional Feature:
- Macro: MESSBAUER_SWEEP_COUNTER_EN.
- Defined: adds output sweep_count (32 bits).
  - Increments on each completed sweep (commit of channel CHANNEL_NUMBER-1); a restart by start does not count.
  - Resets to 0 on areset and on completion of CLEAR; saturates at all-ones.
- Undefined: the port and its logic are absent.

Decomposition:
- Shared package/include messbauer_defs: FSM state encoding, default CHANNEL_NUMBER (512), COUNTER_WIDTH, and a clog2 function.
- Sub-module messbauer_input_conditioner: synchronizers, edge detectors and the coincidence-window discriminator. It outputs start_edge, channel_edge and event_accept.

Test Plan:
- Clear, then start + 512 channel pulses 20 cycles apart, 3 lone lower pulses in channel 5 -> rd_addr=5 gives 3, every other address gives 0, busy low at end.
- Lower pulse then upper pulse 2 cycles later (window 4) -> no count. Upper pulse 6 cycles later -> 1 count.
- Two sweeps, 1 event in channel 10 each -> RAM[10]=2. With MESSBAUER_SWEEP_COUNTER_EN, sweep_count=2.
- Preload RAM[0]=32'hFFFF_FFFE, 5 events in channel 0 -> RAM[0]=32'hFFFF_FFFF (saturated).
- Assert areset during COMMIT_WR, then release -> busy=0, FSM in IDLE, rd_valid=0. After clear, all addresses read 0.
- rd_en for address 7 in the same cycle as a commit write to address 7 (old value 4, new 6) -> returns 4; the next read returns 6.
